// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, default frame dimensions and width helpers for the conv datapath
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_HEIGHT     = 224;
  localparam int DEF_WIDTH      = 224;
  // A valid (unpadded) 3x3 convolution trims one pixel from every edge.
  localparam int DEF_OUT_COUNT  = (DEF_HEIGHT - 2) * (DEF_WIDTH - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_STREAM,
    ST_DRAIN
  } seq_state_t;

  // Bits needed to address every pixel of an h x w frame.
  function automatic int addr_width(input int h, input int w);
    return (h * w > 1) ? $clog2(h * w) : 1;
  endfunction

  // Bits needed to hold the values 0..n inclusive.
  function automatic int count_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// rtl/seq_counter.sv - up-counter with clear, load, enable and terminal-count flag
module seq_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TERMINAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  // Clear beats load beats enable; the count wraps if enabled past all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TERMINAL);

endmodule

// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - weight load, frame streaming and result counting for the RGB conv layer
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SETTLE_CYC = 5,
  parameter int OUT_COUNT  = DEF_OUT_COUNT,
  parameter int DRAIN_MAX  = 1024,
  localparam int ADDR_W    = addr_width(HEIGHT, WIDTH),
  localparam int OUT_W     = count_width(OUT_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pause,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_r,
  input  logic [DATA_WIDTH-1:0] mem_g,
  input  logic [DATA_WIDTH-1:0] mem_b,
  output logic                  load_weight,
  output logic [DATA_WIDTH-1:0] pixel_in_r,
  output logic [DATA_WIDTH-1:0] pixel_in_g,
  output logic [DATA_WIDTH-1:0] pixel_in_b,
  output logic                  pixel_valid,
  input  logic                  conv_valid,
  output logic [OUT_W-1:0]      out_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  localparam int SET_W = count_width(SETTLE_CYC);
  localparam int DRN_W = count_width(DRAIN_MAX);

  localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(HEIGHT * WIDTH - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [DRN_W-1:0]  DRAIN_LAST  = DRN_W'(DRAIN_MAX - 1);
  localparam logic [OUT_W-1:0]  OUT_FULL    = OUT_W'(OUT_COUNT);
  localparam logic [OUT_W-1:0]  OUT_LAST    = OUT_W'(OUT_COUNT - 1);

  seq_state_t state_q, state_d;

  logic             start_accept;
  logic             addr_last;
  logic             settle_last;
  logic             drain_last;
  logic             out_full;
  logic             frame_full;
  logic             drain_expired;
  logic             out_count_en;
  logic             in_result_window;
  logic             done_d, timeout_d;
  logic [SET_W-1:0] settle_count;
  logic [DRN_W-1:0] drain_count;
  logic             unused_counts;

  assign unused_counts    = ^{settle_count, drain_count};
  assign start_accept     = (state_q == ST_IDLE) && start && !abort;
  assign in_result_window = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign out_count_en     = conv_valid && in_result_window && !abort && !out_full;
  // The last beat closes the frame in the very cycle it arrives.
  assign frame_full       = out_full || (conv_valid && (out_idx == OUT_LAST));
  // A beat this cycle restarts the idle count, so it can never also expire.
  assign drain_expired    = (state_q == ST_DRAIN) && drain_last && !conv_valid;

  seq_counter #(.WIDTH(ADDR_W), .TERMINAL(ADDR_LAST)) u_addr_counter (
    .clk(clk), .rst_n(rst_n), .clear(start_accept), .load(1'b0), .load_value('0),
    .enable(mem_rd_en), .count(mem_addr), .terminal(addr_last)
  );

  seq_counter #(.WIDTH(SET_W), .TERMINAL(SETTLE_LAST)) u_settle_counter (
    .clk(clk), .rst_n(rst_n), .clear(state_q != ST_SETTLE), .load(1'b0), .load_value('0),
    .enable(state_q == ST_SETTLE), .count(settle_count), .terminal(settle_last)
  );

  seq_counter #(.WIDTH(OUT_W), .TERMINAL(OUT_FULL)) u_out_counter (
    .clk(clk), .rst_n(rst_n), .clear(start_accept), .load(1'b0), .load_value('0),
    .enable(out_count_en), .count(out_idx), .terminal(out_full)
  );

  seq_counter #(.WIDTH(DRN_W), .TERMINAL(DRAIN_LAST)) u_drain_counter (
    .clk(clk), .rst_n(rst_n), .clear((state_q != ST_DRAIN) || conv_valid), .load(1'b0),
    .load_value('0), .enable(state_q == ST_DRAIN), .count(drain_count), .terminal(drain_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SETTLE;
      ST_SETTLE: if (settle_last) state_d = ST_STREAM;
      ST_STREAM: if (mem_rd_en && addr_last) state_d = ST_DRAIN;
      ST_DRAIN:  if (frame_full || drain_expired) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Moore strobes plus the read request and the end-of-frame pulse conditions.
  always_comb begin
    load_weight = (state_q == ST_LOAD);
    busy        = (state_q != ST_IDLE);
    mem_rd_en   = (state_q == ST_STREAM) && !pause && !abort;
    done_d      = (state_q == ST_DRAIN) && !abort && frame_full;
    timeout_d   = (state_q == ST_DRAIN) && !abort && !frame_full && drain_expired;
  end

  // One-cycle delayed copies: pixel_valid tracks the RAM read latency, done/timeout are pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      pixel_valid <= mem_rd_en;
      done        <= done_d;
      timeout     <= timeout_d;
    end
  end

  // The RAM output register holds the pixel; it is forwarded only while valid.
  always_comb begin
    pixel_in_r = pixel_valid ? mem_r : '0;
    pixel_in_g = pixel_valid ? mem_g : '0;
    pixel_in_b = pixel_valid ? mem_b : '0;
  end

endmodule
